// File: rtl/mdio_pkg.sv
// Shared types and frame constants for the Clause 22 MDIO master.
package mdio_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    HDR,
    TA,
    DATA,
    DONE
  } mdio_state_e;

  localparam logic [1:0] MDIO_ST    = 2'b01;
  localparam logic [1:0] MDIO_OP_WR = 2'b01;
  localparam logic [1:0] MDIO_OP_RD = 2'b10;
  localparam logic [1:0] MDIO_TA_WR = 2'b10;

  localparam logic [4:0] HDR_LAST  = 5'd13;
  localparam logic [4:0] TA_LAST   = 5'd1;
  localparam logic [4:0] DATA_LAST = 5'd15;

  // ST, OP, PHYAD, REGAD packed MSB first in transmit order
  function automatic logic [13:0] mdio_header(input logic       wr,
                                              input logic [4:0] phy_addr,
                                              input logic [4:0] reg_addr);
    return {MDIO_ST, (wr ? MDIO_OP_WR : MDIO_OP_RD), phy_addr, reg_addr};
  endfunction

endpackage

// File: rtl/mdio_clk_gen.sv
// MDC generator: CLK_DIV cycles low then CLK_DIV cycles high, with phase strobes.
module mdio_clk_gen #(
  parameter int unsigned CLK_DIV = 25
) (
  input  logic clock,
  input  logic reset_n,
  input  logic en,
  output logic mgmt_clk,
  output logic fall,
  output logic sample
);

  localparam logic [7:0] HALF_LAST = 8'(CLK_DIV - 1);

  logic [7:0] half_cnt;

  // Disabled means parked low at the start of a low phase, so the first
  // enabled cycle is already the first low cycle of bit 0.
  always_ff @(posedge clock) begin
    if (!reset_n || !en) begin
      half_cnt <= '0;
      mgmt_clk <= 1'b0;
    end else if (half_cnt == HALF_LAST) begin
      half_cnt <= '0;
      mgmt_clk <= ~mgmt_clk;
    end else begin
      half_cnt <= half_cnt + 8'd1;
    end
  end

  assign fall   = en && !mgmt_clk && (half_cnt == '0);
  assign sample = en &&  mgmt_clk && (half_cnt == HALF_LAST);

endmodule

// File: rtl/mdio_master.sv
// Clause 22 MDIO master: one register read/write per request, one response pulse each.
module mdio_master #(
  parameter int unsigned CLK_DIV       = 25,
  parameter int unsigned PREAMBLE_BITS = 32
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [4:0]  req_phy_addr,
  input  logic [4:0]  req_reg_addr,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy,
  output logic        mgmt_clk,
  output logic        mgmt_dataOut,
  output logic        mgmt_outEn,
  input  logic        mgmt_dataIn
);

  import mdio_pkg::*;

  localparam logic [4:0] PRE_LAST  = (PREAMBLE_BITS == 0) ? 5'd0 : 5'(PREAMBLE_BITS - 1);
  localparam logic       FIRST_BIT = (PREAMBLE_BITS == 0) ? MDIO_ST[1] : 1'b1;

  mdio_state_e state, state_next;

  logic [4:0]  bit_cnt;
  logic        last_bit;
  logic        accept;
  logic        clk_en;
  logic        fall;
  logic        sample;
  logic        wr_q;
  logic [13:0] header_q;
  logic [15:0] wdata_q;
  logic [15:0] shift_q;
  logic        ta_err_q;
  logic [1:0]  sync_q;
  logic        frame_bit;
  logic        frame_oe;

  assign accept    = req_valid && (state == IDLE);
  assign req_ready = (state == IDLE);
  assign busy      = !req_ready;
  assign rsp_valid = (state == DONE);
  assign clk_en    = (state != IDLE) && (state != DONE);

  mdio_clk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_gen (
    .clock    (clock),
    .reset_n  (reset_n),
    .en       (clk_en),
    .mgmt_clk (mgmt_clk),
    .fall     (fall),
    .sample   (sample)
  );

  always_comb begin
    state_next = state;
    last_bit   = 1'b0;
    case (state)
      IDLE: begin
        if (accept) state_next = (PREAMBLE_BITS == 0) ? HDR : PRE;
      end
      PRE: begin
        last_bit = (bit_cnt == PRE_LAST);
        if (sample && last_bit) state_next = HDR;
      end
      HDR: begin
        last_bit = (bit_cnt == HDR_LAST);
        if (sample && last_bit) state_next = TA;
      end
      TA: begin
        last_bit = (bit_cnt == TA_LAST);
        if (sample && last_bit) state_next = DATA;
      end
      DATA: begin
        last_bit = (bit_cnt == DATA_LAST);
        if (sample && last_bit) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Value and enable for the bit period currently in progress; reads release the line from TA on.
  always_comb begin
    frame_bit = 1'b1;
    frame_oe  = 1'b0;
    case (state)
      PRE: frame_oe = 1'b1;
      HDR: begin
        frame_oe  = 1'b1;
        frame_bit = header_q[4'd13 - bit_cnt[3:0]];
      end
      TA: begin
        frame_oe  = wr_q;
        frame_bit = wr_q ? (bit_cnt[0] ? MDIO_TA_WR[0] : MDIO_TA_WR[1]) : 1'b1;
      end
      DATA: begin
        frame_oe  = wr_q;
        frame_bit = wr_q ? wdata_q[4'd15 - bit_cnt[3:0]] : 1'b1;
      end
      default: begin
        frame_bit = 1'b1;
        frame_oe  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      wr_q         <= 1'b0;
      header_q     <= '0;
      wdata_q      <= '0;
      shift_q      <= '0;
      ta_err_q     <= 1'b0;
      sync_q       <= '1;
      mgmt_dataOut <= 1'b1;
      mgmt_outEn   <= 1'b0;
      rsp_rdata    <= '0;
      rsp_err      <= 1'b0;
    end else begin
      state  <= state_next;
      sync_q <= {sync_q[0], mgmt_dataIn};

      if (state == IDLE) begin
        bit_cnt <= '0;
        if (accept) begin
          wr_q         <= req_write;
          header_q     <= mdio_header(req_write, req_phy_addr, req_reg_addr);
          wdata_q      <= req_wdata;
          // Drive bit 0 from the accept edge so the frame is owned from its first cycle
          mgmt_dataOut <= FIRST_BIT;
          mgmt_outEn   <= 1'b1;
        end
      end else if (sample) begin
        bit_cnt <= last_bit ? '0 : bit_cnt + 5'd1;
        if ((state == TA) && bit_cnt[0]) ta_err_q <= sync_q[1];
        if (state == DATA) shift_q <= {shift_q[14:0], sync_q[1]};
      end

      if (fall) begin
        mgmt_dataOut <= frame_bit;
        mgmt_outEn   <= frame_oe;
      end

      // Entering DONE: publish the response and return the line to idle
      if (sample && (state == DATA) && last_bit) begin
        rsp_rdata    <= wr_q ? 16'h0000 : {shift_q[14:0], sync_q[1]};
        rsp_err      <= !wr_q && ta_err_q;
        mgmt_dataOut <= 1'b1;
        mgmt_outEn   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mdio_master.sv
// Directed bench for mdio_master: CLK_DIV=4 with preamble, plus CLK_DIV=3 without preamble.
module tb_mdio_master;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset_n   = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_valid2 = 1'b0;
  logic        req_write = 1'b0;
  logic [4:0]  req_phy_addr = '0;
  logic [4:0]  req_reg_addr = '0;
  logic [15:0] req_wdata = '0;

  logic        req_ready, rsp_valid, rsp_err, busy;
  logic        mgmt_clk, mgmt_dataOut, mgmt_outEn;
  logic        mgmt_dataIn = 1'b1;
  logic [15:0] rsp_rdata;

  logic        req_ready_2, rsp_valid_2, rsp_err_2, busy_2;
  logic        mgmt_clk_2, mgmt_dataOut_2, mgmt_outEn_2;
  logic [15:0] rsp_rdata_2;

  mdio_master #(.CLK_DIV(4), .PREAMBLE_BITS(32)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_phy_addr(req_phy_addr), .req_reg_addr(req_reg_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
    .mgmt_clk(mgmt_clk), .mgmt_dataOut(mgmt_dataOut), .mgmt_outEn(mgmt_outEn),
    .mgmt_dataIn(mgmt_dataIn)
  );

  mdio_master #(.CLK_DIV(3), .PREAMBLE_BITS(0)) dut2 (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid2), .req_ready(req_ready_2), .req_write(req_write),
    .req_phy_addr(req_phy_addr), .req_reg_addr(req_reg_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid_2), .rsp_rdata(rsp_rdata_2), .rsp_err(rsp_err_2), .busy(busy_2),
    .mgmt_clk(mgmt_clk_2), .mgmt_dataOut(mgmt_dataOut_2), .mgmt_outEn(mgmt_outEn_2),
    .mgmt_dataIn(1'b1)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // PHY model and monitor for dut
  int          phy_mode = 0;
  logic [15:0] phy_data = '0;
  int          cyc = 0, gcyc = 0, rise_cnt = 0, rsp_cnt = 0, acc_cnt = 0;
  int          rsp_cyc = 0, rsp_gcyc = 0, last_acc = 0, prev_acc = 0, busy_bad = 0;
  logic        prev_mdc = 1'b0;
  logic [63:0] cap_do = '0, cap_oe = '0;
  logic [15:0] rsp_data_seen = '0;
  logic        rsp_err_seen = 1'b0;

  function automatic logic phy_bit(input int idx);
    if (phy_mode == 0) return 1'b1;
    if (idx == 47) return 1'b0;
    if (idx >= 48 && idx <= 63) return phy_data[4'(63 - idx)];
    return 1'b1;
  endfunction

  always @(negedge clock) begin
    gcyc++;
    cyc++;
    if (reset_n && (busy !== !req_ready)) busy_bad++;
    if (mgmt_clk && !prev_mdc) begin
      cap_do = {cap_do[62:0], mgmt_dataOut};
      cap_oe = {cap_oe[62:0], mgmt_outEn};
      rise_cnt++;
    end
    if (!mgmt_clk && prev_mdc) mgmt_dataIn = phy_bit(rise_cnt);
    prev_mdc = mgmt_clk;
    if (rsp_valid) begin
      rsp_cnt++;
      rsp_cyc = cyc;
      rsp_gcyc = gcyc;
      rsp_data_seen = rsp_rdata;
      rsp_err_seen = rsp_err;
    end
    if (req_valid && req_ready) begin
      cyc = 0;
      rise_cnt = 0;
      mgmt_dataIn = 1'b1;
      acc_cnt++;
      prev_acc = last_acc;
      last_acc = gcyc;
      cap_do = '0;
      cap_oe = '0;
    end
  end

  // Monitor for dut2
  int          cyc2 = 0, rsp2_cnt = 0, rsp2_cyc = 0;
  logic        prev_mdc2 = 1'b0;
  logic [31:0] cap2_do = '0, cap2_oe = '0;
  logic [15:0] rsp2_data = '0;
  logic        rsp2_err = 1'b0;

  always @(negedge clock) begin
    cyc2++;
    if (mgmt_clk_2 && !prev_mdc2) begin
      cap2_do = {cap2_do[30:0], mgmt_dataOut_2};
      cap2_oe = {cap2_oe[30:0], mgmt_outEn_2};
    end
    prev_mdc2 = mgmt_clk_2;
    if (rsp_valid_2) begin
      rsp2_cnt++;
      rsp2_cyc = cyc2;
      rsp2_data = rsp_rdata_2;
      rsp2_err = rsp_err_2;
    end
    if (req_valid2 && req_ready_2) cyc2 = 0;
  end

  task automatic issue(input logic which, input logic wr, input logic [4:0] pa,
                       input logic [4:0] ra, input logic [15:0] wd, output logic ok);
    @(posedge clock); #1;
    req_write = wr; req_phy_addr = pa; req_reg_addr = ra; req_wdata = wd;
    if (which) req_valid2 = 1'b1; else req_valid = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 2000 && !ok; n++) begin
      @(negedge clock);
      ok = which ? req_ready_2 : req_ready;
    end
    @(posedge clock); #1;
    req_valid = 1'b0;
    req_valid2 = 1'b0;
  endtask

  task automatic wait_rsp(input logic which, input int base, output logic ok);
    ok = 1'b0;
    for (int n = 0; n < 5000 && !ok; n++) begin
      @(posedge clock);
      ok = which ? (rsp2_cnt > base) : (rsp_cnt > base);
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    n_checks++;
    if ({req_ready, busy, rsp_valid, rsp_err, mgmt_clk, mgmt_dataOut, mgmt_outEn} !== 7'b1000010) begin
      $display("FAIL reset_ctrl: got %b expected 1000010", {req_ready, busy, rsp_valid, rsp_err, mgmt_clk, mgmt_dataOut, mgmt_outEn});
      n_fail++;
    end
    n_checks++;
    if (rsp_rdata !== 16'h0000) begin
      $display("FAIL reset_rdata: got %h expected 0000", rsp_rdata);
      n_fail++;
    end
    @(posedge clock); #1 reset_n = 1'b1;
    @(negedge clock);
    n_checks++;
    if ({req_ready, busy, rsp_valid, mgmt_clk, mgmt_dataOut, mgmt_outEn} !== 6'b100010) begin
      $display("FAIL reset_exit: got %b expected 100010", {req_ready, busy, rsp_valid, mgmt_clk, mgmt_dataOut, mgmt_outEn});
      n_fail++;
    end
    n_checks++;
    if ({req_ready_2, busy_2, rsp_valid_2, mgmt_clk_2, mgmt_dataOut_2, mgmt_outEn_2} !== 6'b100010) begin
      $display("FAIL reset_exit_dut2: got %b expected 100010", {req_ready_2, busy_2, rsp_valid_2, mgmt_clk_2, mgmt_dataOut_2, mgmt_outEn_2});
      n_fail++;
    end
  endtask

  task automatic test_write;
    logic ok;
    int   base;
    phy_mode = 0;
    base = rsp_cnt;
    issue(1'b0, 1'b1, 5'd1, 5'd0, 16'h1140, ok);
    wait_rsp(1'b0, base, ok);
    n_checks++;
    if (!ok) begin $display("FAIL write_rsp: got timeout expected rsp_valid"); n_fail++; end
    n_checks++;
    if (cap_do !== 64'hFFFF_FFFF_5082_1140) begin
      $display("FAIL write_frame: got %h expected ffffffff50821140", cap_do); n_fail++;
    end
    n_checks++;
    if (cap_oe !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      $display("FAIL write_oe: got %h expected ffffffffffffffff", cap_oe); n_fail++;
    end
    n_checks++;
    if (rsp_cyc !== 513) begin $display("FAIL write_latency: got %0d expected 513", rsp_cyc); n_fail++; end
    n_checks++;
    if ({rsp_data_seen, rsp_err_seen} !== 17'h0) begin
      $display("FAIL write_rsp_data: got %h/%b expected 0000/0", rsp_data_seen, rsp_err_seen); n_fail++;
    end
    n_checks++;
    if (rise_cnt !== 64) begin $display("FAIL write_bits: got %0d expected 64", rise_cnt); n_fail++; end
    @(negedge clock);
    n_checks++;
    if ({req_ready, mgmt_clk, mgmt_dataOut, mgmt_outEn} !== 4'b1010) begin
      $display("FAIL write_idle_after: got %b expected 1010", {req_ready, mgmt_clk, mgmt_dataOut, mgmt_outEn}); n_fail++;
    end
  endtask

  task automatic test_read(input int mode, input logic [15:0] exp_data, input logic exp_err);
    logic        ok;
    int          base;
    logic [45:0] exp_hdr;
    logic [45:0] got_hdr;
    phy_mode = mode;
    phy_data = 16'h796D;
    exp_hdr  = {32'hFFFF_FFFF, 14'h1862};
    base = rsp_cnt;
    issue(1'b0, 1'b0, 5'd3, 5'd2, 16'hDEAD, ok);
    wait_rsp(1'b0, base, ok);
    got_hdr = cap_do[63:18];
    n_checks++;
    if (!ok) begin $display("FAIL read_rsp(mode %0d): got timeout expected rsp_valid", mode); n_fail++; end
    n_checks++;
    if (got_hdr !== exp_hdr) begin
      $display("FAIL read_header(mode %0d): got %h expected %h", mode, got_hdr, exp_hdr); n_fail++;
    end
    n_checks++;
    if (cap_oe !== 64'hFFFF_FFFF_FFFC_0000) begin
      $display("FAIL read_oe(mode %0d): got %h expected fffffffffffc0000", mode, cap_oe); n_fail++;
    end
    n_checks++;
    if (rsp_data_seen !== exp_data) begin
      $display("FAIL read_data(mode %0d): got %h expected %h", mode, rsp_data_seen, exp_data); n_fail++;
    end
    n_checks++;
    if (rsp_err_seen !== exp_err) begin
      $display("FAIL read_err(mode %0d): got %b expected %b", mode, rsp_err_seen, exp_err); n_fail++;
    end
    @(negedge clock);
    n_checks++;
    if ({rsp_rdata, rsp_err} !== {exp_data, exp_err}) begin
      $display("FAIL read_hold(mode %0d): got %h/%b expected %h/%b", mode, rsp_rdata, rsp_err, exp_data, exp_err); n_fail++;
    end
  endtask

  task automatic test_back_to_back;
    int   a0, r0, first_rsp_g;
    logic ok;
    phy_mode = 0;
    a0 = acc_cnt;
    r0 = rsp_cnt;
    @(posedge clock); #1;
    req_write = 1'b1; req_phy_addr = 5'd2; req_reg_addr = 5'd4; req_wdata = 16'h0F0F;
    req_valid = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 100 && !ok; n++) begin @(posedge clock); ok = (acc_cnt == a0 + 1); end
    #1;
    req_write = 1'b0; req_phy_addr = 5'd7; req_reg_addr = 5'd9;
    repeat (100) @(negedge clock);
    n_checks++;
    if ({busy, req_ready} !== 2'b10) begin
      $display("FAIL b2b_busy: got busy/ready %b expected 10", {busy, req_ready}); n_fail++;
    end
    ok = 1'b0;
    for (int n = 0; n < 2000 && !ok; n++) begin @(posedge clock); ok = (rsp_cnt == r0 + 1); end
    first_rsp_g = rsp_gcyc;
    n_checks++;
    if (!ok || rsp_data_seen !== 16'h0000) begin
      $display("FAIL b2b_first_rsp: got ok=%b data %h expected ok=1 data 0000", ok, rsp_data_seen); n_fail++;
    end
    ok = 1'b0;
    for (int n = 0; n < 100 && !ok; n++) begin @(posedge clock); ok = (acc_cnt == a0 + 2); end
    #1 req_valid = 1'b0;
    n_checks++;
    if (last_acc - first_rsp_g !== 1) begin
      $display("FAIL b2b_accept_gap: got %0d expected 1", last_acc - first_rsp_g); n_fail++;
    end
    n_checks++;
    if (last_acc - prev_acc !== 514) begin
      $display("FAIL b2b_accept_period: got %0d expected 514", last_acc - prev_acc); n_fail++;
    end
    wait_rsp(1'b0, r0 + 1, ok);
    n_checks++;
    if (!ok || {rsp_data_seen, rsp_err_seen} !== {16'hFFFF, 1'b1}) begin
      $display("FAIL b2b_second_rsp: got ok=%b %h/%b expected ok=1 ffff/1", ok, rsp_data_seen, rsp_err_seen); n_fail++;
    end
    n_checks++;
    if (busy_bad !== 0) begin $display("FAIL busy_vs_ready: got %0d bad cycles expected 0", busy_bad); n_fail++; end
  endtask

  task automatic test_reset_mid;
    logic ok;
    int   r0;
    r0 = rsp_cnt;
    issue(1'b0, 1'b1, 5'd1, 5'd1, 16'h1234, ok);
    ok = 1'b0;
    for (int n = 0; n < 500 && !ok; n++) begin @(posedge clock); ok = (rise_cnt == 10); end
    repeat (5) @(posedge clock);
    #1 reset_n = 1'b0;
    @(posedge clock); #1 reset_n = 1'b1;
    @(negedge clock);
    n_checks++;
    if ({req_ready, rsp_valid, mgmt_clk, mgmt_dataOut, mgmt_outEn} !== 5'b10010) begin
      $display("FAIL midreset_state: got %b expected 10010", {req_ready, rsp_valid, mgmt_clk, mgmt_dataOut, mgmt_outEn}); n_fail++;
    end
    repeat (600) @(posedge clock);
    n_checks++;
    if (rsp_cnt !== r0) begin $display("FAIL midreset_no_rsp: got %0d expected %0d", rsp_cnt, r0); n_fail++; end
    issue(1'b0, 1'b1, 5'h15, 5'h0B, 16'hBEEF, ok);
    wait_rsp(1'b0, r0, ok);
    n_checks++;
    if (!ok || cap_do !== 64'hFFFF_FFFF_5AAE_BEEF) begin
      $display("FAIL midreset_next_frame: got ok=%b %h expected ok=1 ffffffff5aaebeef", ok, cap_do); n_fail++;
    end
    n_checks++;
    if (rsp_cyc !== 513) begin $display("FAIL midreset_next_latency: got %0d expected 513", rsp_cyc); n_fail++; end
  endtask

  task automatic test_no_preamble;
    logic       ok;
    int         base;
    logic [1:0] st_bits;
    base = rsp2_cnt;
    issue(1'b1, 1'b1, 5'h1F, 5'h0A, 16'hA5C3, ok);
    wait_rsp(1'b1, base, ok);
    st_bits = cap2_do[31:30];
    n_checks++;
    if (!ok || rsp2_cyc !== 193) begin
      $display("FAIL nopre_latency: got ok=%b cycle %0d expected ok=1 cycle 193", ok, rsp2_cyc); n_fail++;
    end
    n_checks++;
    if (st_bits !== 2'b01) begin $display("FAIL nopre_st: got %b expected 01", st_bits); n_fail++; end
    n_checks++;
    if (cap2_do !== 32'h5FAA_A5C3) begin $display("FAIL nopre_frame: got %h expected 5faaa5c3", cap2_do); n_fail++; end
    n_checks++;
    if (cap2_oe !== 32'hFFFF_FFFF) begin $display("FAIL nopre_oe: got %h expected ffffffff", cap2_oe); n_fail++; end
    n_checks++;
    if ({rsp2_data, rsp2_err} !== 17'h0) begin
      $display("FAIL nopre_rsp_data: got %h/%b expected 0000/0", rsp2_data, rsp2_err); n_fail++;
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read(1, 16'h796D, 1'b0);
    test_read(0, 16'hFFFF, 1'b1);
    test_back_to_back();
    test_reset_mid();
    test_no_preamble();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1);
  end

endmodule
